// File: rtl/alu_result_skid_if.sv
// Handshake bundle between the RV32I EX stage, the result skid buffer and
// the MEM/writeback stage. The master drives the upstream beat, flush and
// downstream ready; the slave (the skid buffer) drives everything else.
//
// Handshake rule for both sides: a beat transfers on a rising edge where
// valid and ready are both 1; the producer holds its beat stable until then,
// and ready never depends combinationally on valid.
interface alu_result_skid_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  // upstream (EX stage) beat
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_alu_out;
  logic              in_branch_en;
  logic              in_is_branch;
  logic [RD_W-1:0]   in_rd;
  logic              in_reg_write;
  logic [DATA_W-1:0] in_branch_target;
  // front-end flush
  logic              flush;
  // downstream (MEM/WB) head
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_alu_out;
  logic [RD_W-1:0]   out_rd;
  logic              out_reg_write;
  // taken-branch redirect
  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;
  // debug view of internal state (occupancy and squash mode)
  logic [1:0]        dbg_state;
  logic              dbg_squash;

  modport master (
    output in_valid, in_alu_out, in_branch_en, in_is_branch, in_rd,
           in_reg_write, in_branch_target, flush, out_ready,
    input  in_ready, out_valid, out_alu_out, out_rd, out_reg_write,
           redirect_valid, redirect_pc, dbg_state, dbg_squash
  );

  modport slave (
    input  in_valid, in_alu_out, in_branch_en, in_is_branch, in_rd,
           in_reg_write, in_branch_target, flush, out_ready,
    output in_ready, out_valid, out_alu_out, out_rd, out_reg_write,
           redirect_valid, redirect_pc, dbg_state, dbg_squash
  );
endinterface

// File: rtl/alu_result_skid.sv
// Two-entry registered skid buffer behind the ALU. Holds EX results in a
// head/skid pair, presents the head downstream, pulses a redirect for taken
// branches and drops wrong-path beats until the front end flushes.
module alu_result_skid #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input logic               clk,
  input logic               reset_n,
  alu_result_skid_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef enum logic {
    MODE_RUN    = 1'b0,
    MODE_SQUASH = 1'b1
  } mode_e;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic              in_ready_q, in_ready_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;

  // head entry (what downstream sees) and skid entry (absorbs the beat in flight)
  logic [DATA_W-1:0] h_alu_q, h_alu_d;
  logic [RD_W-1:0]   h_rd_q, h_rd_d;
  logic              h_wr_q, h_wr_d;
  logic [DATA_W-1:0] s_alu_q, s_alu_d;
  logic [RD_W-1:0]   s_rd_q, s_rd_d;
  logic              s_wr_q, s_wr_d;

  logic accept;
  logic pop;
  logic store;
  logic taken;
  logic in_wr;

  assign accept = bus.in_valid & in_ready_q;
  assign pop    = (state_q != ST_EMPTY) & bus.out_ready;
  // Wrong-path beats are consumed but never stored while squashing.
  assign store  = accept & (mode_q == MODE_RUN);
  assign taken  = store & bus.in_is_branch & bus.in_branch_en;
  // Branches never write rd, and x0 is never written; folded in at capture.
  assign in_wr  = bus.in_reg_write & ~bus.in_is_branch & (bus.in_rd != '0);

  // Next-state: occupancy, entry data, squash mode, redirect and in_ready.
  always_comb begin
    state_d          = state_q;
    mode_d           = mode_q;
    h_alu_d          = h_alu_q;
    h_rd_d           = h_rd_q;
    h_wr_d           = h_wr_q;
    s_alu_d          = s_alu_q;
    s_rd_d           = s_rd_q;
    s_wr_d           = s_wr_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    case (state_q)
      ST_EMPTY: begin
        if (store) begin
          state_d = ST_ONE;
          h_alu_d = bus.in_alu_out;
          h_rd_d  = bus.in_rd;
          h_wr_d  = in_wr;
        end
      end
      ST_ONE: begin
        if (store && !pop) begin
          state_d = ST_TWO;
          s_alu_d = bus.in_alu_out;
          s_rd_d  = bus.in_rd;
          s_wr_d  = in_wr;
        end else if (store && pop) begin
          h_alu_d = bus.in_alu_out;
          h_rd_d  = bus.in_rd;
          h_wr_d  = in_wr;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so nothing can be accepted.
        if (pop) begin
          state_d = ST_ONE;
          h_alu_d = s_alu_q;
          h_rd_d  = s_rd_q;
          h_wr_d  = s_wr_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (taken) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = bus.in_branch_target;
      mode_d           = MODE_SQUASH;
    end

    // Flush wins over everything except reset; it never raises a redirect.
    if (bus.flush) begin
      state_d          = ST_EMPTY;
      mode_d           = MODE_RUN;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
    end

    in_ready_d = (state_d != ST_TWO);
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= ST_EMPTY;
      mode_q           <= MODE_RUN;
      in_ready_q       <= 1'b1;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      h_alu_q          <= '0;
      h_rd_q           <= '0;
      h_wr_q           <= 1'b0;
      s_alu_q          <= '0;
      s_rd_q           <= '0;
      s_wr_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      in_ready_q       <= in_ready_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      h_alu_q          <= h_alu_d;
      h_rd_q           <= h_rd_d;
      h_wr_q           <= h_wr_d;
      s_alu_q          <= s_alu_d;
      s_rd_q           <= s_rd_d;
      s_wr_q           <= s_wr_d;
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = (state_q != ST_EMPTY);
  assign bus.out_alu_out    = h_alu_q;
  assign bus.out_rd         = h_rd_q;
  assign bus.out_reg_write  = h_wr_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.dbg_state      = state_q;
  assign bus.dbg_squash     = (mode_q == MODE_SQUASH);

endmodule

// File: tb/tb_alu_result_skid.sv
// Directed bench for alu_result_skid: streaming, back-pressure, taken and
// not-taken branches, flush, rd==0 and mid-operation reset.
module tb_alu_result_skid;

  logic clk;
  logic reset_n;
  int   pass_cnt;
  int   total_cnt;

  alu_result_skid_if #(.DATA_W(32), .RD_W(5)) bus ();

  alu_result_skid #(.DATA_W(32), .RD_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // advance one edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive_beat(input logic [31:0] alu, input logic [4:0] rd, input logic wr,
                            input logic isb, input logic en, input logic [31:0] tgt);
    bus.in_valid         = 1'b1;
    bus.in_alu_out       = alu;
    bus.in_rd            = rd;
    bus.in_reg_write     = wr;
    bus.in_is_branch     = isb;
    bus.in_branch_en     = en;
    bus.in_branch_target = tgt;
  endtask

  task automatic idle();
    bus.in_valid     = 1'b0;
    bus.in_is_branch = 1'b0;
    bus.in_branch_en = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".out_valid"},      {31'd0, bus.out_valid},      32'd0);
    check({tag, ".out_alu_out"},    bus.out_alu_out,             32'd0);
    check({tag, ".out_rd"},         {27'd0, bus.out_rd},         32'd0);
    check({tag, ".out_reg_write"},  {31'd0, bus.out_reg_write},  32'd0);
    check({tag, ".in_ready"},       {31'd0, bus.in_ready},       32'd1);
    check({tag, ".redirect_valid"}, {31'd0, bus.redirect_valid}, 32'd0);
    check({tag, ".redirect_pc"},    bus.redirect_pc,             32'd0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset_n   = 1'b0;
    bus.in_valid = 1'b0; bus.in_alu_out = '0; bus.in_rd = '0; bus.in_reg_write = 1'b0;
    bus.in_is_branch = 1'b0; bus.in_branch_en = 1'b0; bus.in_branch_target = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;

    // ---- reset ----
    step(); step();
    check_reset_values("reset");
    reset_n = 1'b1;

    // ---- stream of 8 beats with out_ready high ----
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_beat(32'h10 + i, 5'(i + 1), 1'b1, 1'b0, 1'b0, 32'h0);
      check($sformatf("stream.in_ready[%0d]", i), {31'd0, bus.in_ready}, 32'd1);
      step();
      check($sformatf("stream.valid[%0d]", i), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("stream.alu[%0d]", i), bus.out_alu_out, 32'h10 + i);
      check($sformatf("stream.rd[%0d]", i), {27'd0, bus.out_rd}, 32'(i + 1));
      check($sformatf("stream.wr[%0d]", i), {31'd0, bus.out_reg_write}, 32'd1);
    end
    idle();
    step();
    check("stream.drain", {31'd0, bus.out_valid}, 32'd0);

    // ---- back-pressure: 0xA, 0xB stored, 0xC held by source ----
    bus.out_ready = 1'b0;
    drive_beat(32'hA, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("bp.a_head", bus.out_alu_out, 32'hA);
    check("bp.ready_one", {31'd0, bus.in_ready}, 32'd1);
    drive_beat(32'hB, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("bp.ready_two", {31'd0, bus.in_ready}, 32'd0);
    check("bp.head_still_a", bus.out_alu_out, 32'hA);
    drive_beat(32'hC, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("bp.c_blocked_head", bus.out_alu_out, 32'hA);
    check("bp.c_blocked_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    step();
    check("bp.b_out", bus.out_alu_out, 32'hB);
    check("bp.b_valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp.ready_back", {31'd0, bus.in_ready}, 32'd1);
    step();
    check("bp.c_out", bus.out_alu_out, 32'hC);
    check("bp.c_rd", {27'd0, bus.out_rd}, 32'd3);
    idle();
    step();
    check("bp.drain", {31'd0, bus.out_valid}, 32'd0);

    // ---- taken branch, wrong-path squash, flush, recovery ----
    drive_beat(32'h99, 5'd3, 1'b1, 1'b1, 1'b1, 32'h100);
    step();
    check("br.redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
    check("br.redirect_pc", bus.redirect_pc, 32'h100);
    check("br.entry_alu", bus.out_alu_out, 32'h99);
    check("br.entry_wr", {31'd0, bus.out_reg_write}, 32'd0);
    drive_beat(32'h55, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("br.pulse_end", {31'd0, bus.redirect_valid}, 32'd0);
    check("br.pc_hold", bus.redirect_pc, 32'h100);
    check("br.squash_55", {31'd0, bus.out_valid}, 32'd0);
    check("br.squash_mode", {31'd0, bus.dbg_squash}, 32'd1);
    drive_beat(32'h66, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("br.squash_66", {31'd0, bus.out_valid}, 32'd0);
    bus.flush = 1'b1;
    step();
    check("br.flush_valid", {31'd0, bus.out_valid}, 32'd0);
    check("br.flush_mode", {31'd0, bus.dbg_squash}, 32'd0);
    bus.flush = 1'b0;
    drive_beat(32'h77, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("br.after_flush_valid", {31'd0, bus.out_valid}, 32'd1);
    check("br.after_flush_alu", bus.out_alu_out, 32'h77);
    check("br.no_redirect_77", {31'd0, bus.redirect_valid}, 32'd0);
    idle();
    step();

    // ---- not-taken branch then 0x20 ----
    drive_beat(32'h30, 5'd4, 1'b1, 1'b1, 1'b0, 32'h200);
    step();
    check("nt.no_redirect", {31'd0, bus.redirect_valid}, 32'd0);
    check("nt.pc_hold", bus.redirect_pc, 32'h100);
    check("nt.alu", bus.out_alu_out, 32'h30);
    check("nt.wr", {31'd0, bus.out_reg_write}, 32'd0);
    drive_beat(32'h20, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("nt.next_redirect", {31'd0, bus.redirect_valid}, 32'd0);
    check("nt.next_alu", bus.out_alu_out, 32'h20);
    check("nt.next_wr", {31'd0, bus.out_reg_write}, 32'd1);
    idle();
    step();

    // ---- flush in RUN with a beat offered: beat discarded ----
    drive_beat(32'h44, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0);
    bus.flush = 1'b1;
    step();
    check("fl.discard_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.flush = 1'b0;
    idle();

    // ---- flush while TWO full ----
    bus.out_ready = 1'b0;
    drive_beat(32'h1, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    drive_beat(32'h2, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("f2.full_ready", {31'd0, bus.in_ready}, 32'd0);
    check("f2.full_head", bus.out_alu_out, 32'h1);
    drive_beat(32'h3, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
    bus.flush = 1'b1;
    step();
    check("f2.valid", {31'd0, bus.out_valid}, 32'd0);
    check("f2.ready", {31'd0, bus.in_ready}, 32'd1);
    bus.flush = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    step();
    check("f2.not_delivered", {31'd0, bus.out_valid}, 32'd0);

    // ---- rd == 0 never writes ----
    drive_beat(32'h5, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("rd0.valid", {31'd0, bus.out_valid}, 32'd1);
    check("rd0.wr", {31'd0, bus.out_reg_write}, 32'd0);
    idle();
    step();

    // ---- reset while TWO full, overriding flush and a taken branch ----
    bus.out_ready = 1'b0;
    drive_beat(32'h8, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    drive_beat(32'h9, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("rst.full_ready", {31'd0, bus.in_ready}, 32'd0);
    drive_beat(32'hAB, 5'd3, 1'b1, 1'b1, 1'b1, 32'h300);
    bus.flush = 1'b1;
    reset_n   = 1'b0;
    step();
    check_reset_values("rst_mid");
    reset_n   = 1'b1;
    bus.flush = 1'b0;
    idle();
    step();
    check("rst.release_redirect", {31'd0, bus.redirect_valid}, 32'd0);
    check("rst.release_valid", {31'd0, bus.out_valid}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
